miner_core_ccu: RTL and testbench
=================================

// Module: miner_core_ccu
// PURPOSE
//  Central control unit (FSM) of one SHA-256d miner core. A start pulse sequences three SHA-256 block passes:
//  header chunk 0, header chunk 1, then the second hash of the digest. Each pass is message-schedule expansion
//  (48 cyc), compression (64 cyc), then the digest add (1 cyc). Stage lengths come from a companion timer.
// PARAMETERS
//  MSA_CYCLES   48  message-schedule stage length; driven on rollover_val; must fit 7 bits
//  COMP_CYCLES  64  compression stage length; driven on rollover_val; must fit 7 bits
// PORTS
//  clk           in   1  single system clock, rising edge
//  n_rst         in   1  asynchronous, active-low reset
//  hash_enable   in   1  start request; sampled only in IDLE
//  rollover_flag in   1  from timer: high on the final cycle of the current timed stage
//  select        out  1  chunk select: 0 = chunk 0, 1 = chunk 1 (0 in second-hash pass)
//  enable_timer  out  1  high in every MSA/COMP state
//  rollover_val  out  7  MSA_CYCLES in MSA states, COMP_CYCLES in COMP states, else 0
//  msa_en        out  1  first-hash message-schedule stage (both chunks)
//  comp_en       out  1  first-hash compression stage (both chunks)
//  add_en        out  1  first-hash digest add (both chunks)
//  msa2_en       out  1  second-hash message-schedule stage
//  comp2_en      out  1  second-hash compression stage
//  add2_en       out  1  second-hash digest add
//  finished      out  1  one-cycle done pulse
// BEHAVIOUR
//  - Moore FSM; all outputs decoded from the registered state only. Reset: state=IDLE, all outputs 0.
//  - States and transitions (each arrow is taken on a rising clk):
//    IDLE    -> C0_MSA when hash_enable=1, else stay.
//    C0_MSA  -> C0_COMP when rollover_flag=1 (msa_en, select=0).
//    C0_COMP -> C0_ADD when rollover_flag=1 (comp_en, select=0).
//    C0_ADD  -> C1_MSA unconditionally (add_en, select=0).
//    C1_MSA/C1_COMP/C1_ADD: same as the C0 states but select=1.
//    C1_ADD  -> D_MSA.
//    D_MSA   -> D_COMP on flag (msa2_en). D_COMP -> D_ADD on flag (comp2_en).
//    D_ADD   -> DONE (add2_en). DONE -> IDLE (finished=1).
//  - Exactly one stage enable is high in any non-IDLE, non-DONE state.
//  - hash_enable is ignored outside IDLE. No restart or abort is possible except through n_rst.
//  - Timer contract:
//    count resets to 0 when enable_timer=0 or n_rst=0; otherwise it increments each clk.
//    rollover_flag = enable_timer && count==rollover_val-1 (combinational); count wraps to 0 on that cycle.
//    Result: each MSA stage lasts exactly 48 cycles and each COMP stage exactly 64 cycles, including the
//    back-to-back MSA->COMP hand-off where enable_timer stays high.
//  - Latency: hash_enable sampled at edge 0 gives these cycle ranges:
//    C0_MSA 1-48, C0_COMP 49-112, C0_ADD 113,
//    C1_MSA 114-161, C1_COMP 162-225, C1_ADD 226,
//    D_MSA 227-274, D_COMP 275-338, D_ADD 339, finished at cycle 340, IDLE at 341.
//  - A rollover_flag in IDLE, ADD or DONE states is ignored.
//  - Reset mid-operation: asynchronously forces IDLE and all outputs low. The timer clears with it.
// STRUCTURE
//  - Shared package miner_pkg: state enum (IDLE, C0_MSA, ... , DONE), MSA_CYCLES/COMP_CYCLES constants,
//    CNT_W=7.
//  - Natural sub-module: miner_core_ccu_timer (7-bit stage counter + rollover compare). It is instantiated
//    beside the CCU at core level, not inside it.
// TESTING
//  1. Hold n_rst=0 for 2.25 clks -> all outputs 0, state IDLE. Hold hash_enable=0 for 10 clks -> stays idle.
//  2. 1-cycle hash_enable pulse -> msa_en=1 and rollover_val=48 for exactly 48 cycles, then comp_en=1 and
//     rollover_val=64 for exactly 64 cycles, then add_en=1 for 1 cycle; select=0 throughout.
//  3. Continue -> chunk 1 repeats the same 48/64/1 pattern with select=1.
//     Then msa2_en 48, comp2_en 64, add2_en 1, finished 1 at cycle 340, then IDLE.
//  4. Hold hash_enable high during the run -> the sequence is not disturbed. After the return to IDLE with
//     hash_enable still 1, a new run starts on the next cycle.
//  5. Drop n_rst mid C1_COMP -> all outputs clear immediately. After release, idle until the next pulse.
//  6. Check every cycle that exactly one of the six stage enables/finished is high outside IDLE and
//     enable_timer == (msa_en|comp_en|msa2_en|comp2_en).

Source files
------------

// File: rtl/miner_pkg.sv
// Shared types and constants for the SHA-256d miner core control path.
// Holds the CCU state encoding, the stage lengths and the timer width.
package miner_pkg;

    localparam int CNT_W = 7;

    localparam logic [CNT_W-1:0] MSA_CYCLES  = 7'd48;
    localparam logic [CNT_W-1:0] COMP_CYCLES = 7'd64;

    typedef enum logic [3:0] {
        IDLE,
        C0_MSA,
        C0_COMP,
        C0_ADD,
        C1_MSA,
        C1_COMP,
        C1_ADD,
        D_MSA,
        D_COMP,
        D_ADD,
        DONE
    } ccu_state_t;

    // States that are paced by the companion stage timer.
    function automatic logic is_timed(input ccu_state_t st);
        return (st == C0_MSA) || (st == C0_COMP) || (st == C1_MSA) ||
               (st == C1_COMP) || (st == D_MSA) || (st == D_COMP);
    endfunction

endpackage

// File: rtl/miner_core_ccu_timer.sv
// Stage timer for the miner core CCU: counts while enabled and flags the
// final cycle of the current stage, wrapping so timed stages chain back-to-back.
module miner_core_ccu_timer
    import miner_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             enable_timer,
    input  logic [CNT_W-1:0] rollover_val,
    output logic             rollover_flag
);

    logic [CNT_W-1:0] count_q;

    assign rollover_flag = enable_timer && (count_q == (rollover_val - 7'd1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else if (!enable_timer || rollover_flag) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 7'd1;
        end
    end

endmodule

// File: rtl/miner_core_ccu.sv
// Central control unit of one SHA-256d miner core: sequences the two header
// chunk passes and the second-hash pass, each as schedule/compress/add.
//
//  state   | meaning
//  IDLE    | waiting for hash_enable
//  C0_MSA  | chunk 0 message-schedule expansion (timed)
//  C0_COMP | chunk 0 compression (timed)
//  C0_ADD  | chunk 0 digest add
//  C1_MSA  | chunk 1 message-schedule expansion (timed)
//  C1_COMP | chunk 1 compression (timed)
//  C1_ADD  | chunk 1 digest add
//  D_MSA   | second-hash message-schedule expansion (timed)
//  D_COMP  | second-hash compression (timed)
//  D_ADD   | second-hash digest add
//  DONE    | one-cycle finished pulse
module miner_core_ccu
    import miner_pkg::*;
#(
    parameter logic [CNT_W-1:0] MSA_LEN  = MSA_CYCLES,
    parameter logic [CNT_W-1:0] COMP_LEN = COMP_CYCLES
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             hash_enable,
    input  logic             rollover_flag,
    output logic             select,
    output logic             enable_timer,
    output logic [CNT_W-1:0] rollover_val,
    output logic             msa_en,
    output logic             comp_en,
    output logic             add_en,
    output logic             msa2_en,
    output logic             comp2_en,
    output logic             add2_en,
    output logic             finished
);

    ccu_state_t state_q, state_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        select       = 1'b0;
        rollover_val = '0;
        msa_en       = 1'b0;
        comp_en      = 1'b0;
        add_en       = 1'b0;
        msa2_en      = 1'b0;
        comp2_en     = 1'b0;
        add2_en      = 1'b0;
        finished     = 1'b0;
        enable_timer = is_timed(state_q);

        case (state_q)
            IDLE: begin
                if (hash_enable) state_d = C0_MSA;
            end
            C0_MSA: begin
                msa_en       = 1'b1;
                rollover_val = MSA_LEN;
                if (rollover_flag) state_d = C0_COMP;
            end
            C0_COMP: begin
                comp_en      = 1'b1;
                rollover_val = COMP_LEN;
                if (rollover_flag) state_d = C0_ADD;
            end
            C0_ADD: begin
                add_en  = 1'b1;
                state_d = C1_MSA;
            end
            C1_MSA: begin
                select       = 1'b1;
                msa_en       = 1'b1;
                rollover_val = MSA_LEN;
                if (rollover_flag) state_d = C1_COMP;
            end
            C1_COMP: begin
                select       = 1'b1;
                comp_en      = 1'b1;
                rollover_val = COMP_LEN;
                if (rollover_flag) state_d = C1_ADD;
            end
            C1_ADD: begin
                select  = 1'b1;
                add_en  = 1'b1;
                state_d = D_MSA;
            end
            D_MSA: begin
                msa2_en      = 1'b1;
                rollover_val = MSA_LEN;
                if (rollover_flag) state_d = D_COMP;
            end
            D_COMP: begin
                comp2_en     = 1'b1;
                rollover_val = COMP_LEN;
                if (rollover_flag) state_d = D_ADD;
            end
            D_ADD: begin
                add2_en = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                finished = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_miner_core_ccu.sv
// Bench for the miner core CCU closed around its stage timer; every cycle is
// compared against a run-position model built from the stage length table.
`timescale 1ns/1ps
module tb_miner_core_ccu;

    logic       clk;
    logic       n_rst;
    logic       hash_enable;
    logic       rollover_flag;
    logic       select;
    logic       enable_timer;
    logic [6:0] rollover_val;
    logic       msa_en, comp_en, add_en, msa2_en, comp2_en, add2_en, finished;

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  active   = 0;
    int  k        = 0;

    miner_core_ccu dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .hash_enable   (hash_enable),
        .rollover_flag (rollover_flag),
        .select        (select),
        .enable_timer  (enable_timer),
        .rollover_val  (rollover_val),
        .msa_en        (msa_en),
        .comp_en       (comp_en),
        .add_en        (add_en),
        .msa2_en       (msa2_en),
        .comp2_en      (comp2_en),
        .add2_en       (add2_en),
        .finished      (finished)
    );

    miner_core_ccu_timer u_timer (
        .clk           (clk),
        .n_rst         (n_rst),
        .enable_timer  (enable_timer),
        .rollover_val  (rollover_val),
        .rollover_flag (rollover_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stage s (1..10) occupies run cycles (end-dur, end]; 0 means idle.
    function automatic int stage_of(input int kk, output int stage_end);
        int dur[10] = '{48, 64, 1, 48, 64, 1, 48, 64, 1, 1};
        int acc = 0;
        stage_end = 0;
        for (int i = 0; i < 10; i++) begin
            acc += dur[i];
            if (kk >= 1 && kk <= acc) begin
                stage_end = acc;
                return i + 1;
            end
        end
        return 0;
    endfunction

    // {select, enable_timer, rollover_val, msa, comp, add, msa2, comp2, add2, finished}
    function automatic logic [15:0] exp_vec(input int s);
        int kind, pass;
        logic [15:0] v;
        v = '0;
        if (s >= 1 && s <= 9) begin
            kind = (s - 1) % 3;
            pass = (s - 1) / 3;
            v[15] = (pass == 1);
            v[14] = (kind < 2);
            v[13:7] = (kind == 0) ? 7'd48 : (kind == 1) ? 7'd64 : 7'd0;
            v[6] = (kind == 0) && (pass < 2);
            v[5] = (kind == 1) && (pass < 2);
            v[4] = (kind == 2) && (pass < 2);
            v[3] = (kind == 0) && (pass == 2);
            v[2] = (kind == 1) && (pass == 2);
            v[1] = (kind == 2) && (pass == 2);
        end else if (s == 10) begin
            v[0] = 1'b1;
        end
        return v;
    endfunction

    task automatic check_cycle(input string tag);
        int s, send, kind;
        logic [15:0] obs, exp;
        logic exp_flag;
        logic [6:0] stage_bits;
        s   = active ? stage_of(k, send) : 0;
        exp = exp_vec(s);
        kind = (s >= 1) ? (s - 1) % 3 : 2;
        exp_flag = (s >= 1) && (s <= 9) && (kind < 2) && (k == send);
        obs = {select, enable_timer, rollover_val, msa_en, comp_en, add_en,
               msa2_en, comp2_en, add2_en, finished};
        stage_bits = {msa_en, comp_en, add_en, msa2_en, comp2_en, add2_en, finished};

        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s_outputs k=%0d got %h want %h", tag, k, obs, exp);

        n_checks++;
        assert (rollover_flag === exp_flag) n_pass++;
        else $error("FAIL %s_flag k=%0d got %b want %b", tag, k, rollover_flag, exp_flag);

        n_checks++;
        assert ($countones(stage_bits) == ((s != 0) ? 1 : 0)) n_pass++;
        else $error("FAIL %s_onehot k=%0d got %b want %0d set", tag, k, stage_bits, (s != 0));

        n_checks++;
        assert (enable_timer === (msa_en | comp_en | msa2_en | comp2_en)) n_pass++;
        else $error("FAIL %s_entimer k=%0d got %b want %b", tag, k, enable_timer,
                    (msa_en | comp_en | msa2_en | comp2_en));
    endtask

    // One clock: advance the model at the edge, then check 1ns later.
    task automatic step(input string tag);
        @(posedge clk);
        if (!n_rst) begin
            active = 0;
        end else if (active) begin
            k++;
            if (k == 341) active = 0;
        end else if (hash_enable) begin
            active = 1;
            k = 1;
        end
        #1;
        check_cycle(tag);
    endtask

    initial begin
        n_rst       = 1'b0;
        hash_enable = 1'b0;

        // Reset held for 2.25 clocks.
        #2;
        check_cycle("reset_async");
        repeat (2) step("reset_hold");
        #6.5;
        n_rst = 1'b1;
        repeat (10) step("idle");

        // Single pulse: full run, back to idle.
        hash_enable = 1'b1;
        step("pulse");
        hash_enable = 1'b0;
        repeat (350) step("run_pulse");

        // hash_enable held high: run unaffected, then immediate restart.
        hash_enable = 1'b1;
        repeat (400) step("run_held");

        // Random hash_enable activity, both during runs and while idle.
        repeat (900) begin
            hash_enable = ($urandom_range(0, 3) == 0);
            step("run_rand");
        end

        // Drain to idle, then reset in the middle of chunk 1 compression.
        hash_enable = 1'b0;
        for (int i = 0; i < 400 && active; i++) step("drain");
        hash_enable = 1'b1;
        step("pulse2");
        hash_enable = 1'b0;
        for (int i = 0; i < 400 && !(active && k == 162 + $urandom_range(0, 50)); i++)
            step("to_c1comp");
        #2;
        n_rst  = 1'b0;
        active = 0;
        #1;
        check_cycle("reset_mid");
        hash_enable = 1'b1;
        repeat (3) step("reset_mid_hold");
        hash_enable = 1'b0;
        #2;
        n_rst = 1'b1;
        repeat (10) step("post_reset_idle");
        hash_enable = 1'b1;
        step("pulse3");
        hash_enable = 1'b0;
        repeat (345) step("run_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
